// File: rtl/mct_credit_rx_buffer.sv
// Receiver end of the MCT credit link: buffers incoming words in a
// C_DEPTH-entry FIFO, forwards them over valid/ready and returns one
// credit per consumed word, coalesced into multi-credit pulses.
module mct_credit_rx_buffer #(
  parameter int C_DATA_WIDTH   = 64,
  parameter int C_DEPTH        = 16,
  parameter int C_CREDIT_WIDTH = 5,
  parameter int C_COALESCE     = 4,
  parameter int C_TIMEOUT      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [C_DATA_WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [C_DATA_WIDTH-1:0]   out_data,
  output logic                      credit_valid,
  output logic [C_CREDIT_WIDTH-1:0] credit_count,
  output logic                      overflow
);

  localparam int LP_AW = $clog2(C_DEPTH);
  localparam int LP_TW = $clog2(C_TIMEOUT + 1);
  localparam logic [LP_AW:0]          LP_FULL = (LP_AW + 1)'(C_DEPTH);
  localparam logic [LP_TW-1:0]        LP_TMO  = LP_TW'(C_TIMEOUT);
  localparam logic [C_CREDIT_WIDTH-1:0] LP_COAL = C_CREDIT_WIDTH'(C_COALESCE);

  logic [C_DATA_WIDTH-1:0]   r_mem [C_DEPTH];
  logic [LP_AW-1:0]          r_wr_ptr;
  logic [LP_AW-1:0]          r_rd_ptr;
  logic [LP_AW:0]            r_occ;
  logic [C_CREDIT_WIDTH-1:0] r_pending;
  logic [C_CREDIT_WIDTH-1:0] r_credit_count;
  logic [LP_TW-1:0]          r_idle;
  logic                      r_credit_valid;
  logic                      r_overflow;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_flush;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign out_valid = (r_occ != '0);
  assign w_full    = (r_occ == LP_FULL);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = in_valid & (~w_full | w_pop);
  // Return credits once enough are pending, or once a partial batch has sat idle.
  assign w_flush   = (r_pending >= LP_COAL) |
                     ((r_pending != '0) & (r_idle == LP_TMO));

  assign out_data     = r_mem[r_rd_ptr];
  assign credit_valid = r_credit_valid;
  assign credit_count = r_credit_count;
  assign overflow     = r_overflow;

  // Storage array write; contents are data only and carry no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // Pointer/occupancy bookkeeping and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_AW'(1);
      if (w_push & ~w_pop)      r_occ <= r_occ + (LP_AW + 1)'(1);
      else if (w_pop & ~w_push) r_occ <= r_occ - (LP_AW + 1)'(1);
      if (in_valid & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  // Credit accumulation and pulse generation; a pop in the flush cycle opens the next batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending      <= '0;
      r_credit_valid <= 1'b0;
      r_credit_count <= '0;
    end else if (w_flush) begin
      r_credit_valid <= 1'b1;
      r_credit_count <= r_pending;
      r_pending      <= C_CREDIT_WIDTH'(w_pop);
    end else begin
      r_credit_valid <= 1'b0;
      r_credit_count <= '0;
      r_pending      <= r_pending + C_CREDIT_WIDTH'(w_pop);
    end
  end

  // Idle timer for partial batches, saturating at C_TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
    end else if (w_pop | w_flush | (r_pending == '0)) begin
      r_idle <= '0;
    end else if (r_idle != LP_TMO) begin
      r_idle <= r_idle + LP_TW'(1);
    end
  end

endmodule

// File: tb/tb_mct_credit_rx_buffer.sv
// Directed and randomized-sender bench for mct_credit_rx_buffer.
// Two instances share the inputs: default coalescing (4) and coalescing of 1.
module tb_mct_credit_rx_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        ov0, cv0, of0;
  logic [63:0] od0;
  logic [4:0]  cc0;
  logic        ov1, cv1, of1;
  logic [63:0] od1;
  logic [4:0]  cc1;

  bit          sel;
  logic        w_ov, w_cv, w_of;
  logic [63:0] w_od;
  logic [4:0]  w_cc;

  int tests;
  int fails;
  int cyc;

  logic [63:0] exp_q[$];

  int m_pops, m_first_pop, m_last_pop;
  int m_pulses, m_sum, m_first_pulse, m_last_pulse, m_cmax, m_cmin;
  int m_derr, m_czerr;

  mct_credit_rx_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .credit_valid(cv0), .credit_count(cc0), .overflow(of0)
  );

  mct_credit_rx_buffer #(.C_COALESCE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .credit_valid(cv1), .credit_count(cc1), .overflow(of1)
  );

  assign w_ov = sel ? ov1 : ov0;
  assign w_od = sel ? od1 : od0;
  assign w_cv = sel ? cv1 : cv0;
  assign w_cc = sel ? cc1 : cc0;
  assign w_of = sel ? of1 : of0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_words(input int n, input logic [63:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = base + 64'(i);
      exp_q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic mon_clear();
    m_pops = 0; m_first_pop = -1; m_last_pop = -1;
    m_pulses = 0; m_sum = 0; m_first_pulse = -1; m_last_pulse = -1;
    m_cmax = 0; m_cmin = 999; m_derr = 0; m_czerr = 0;
  endtask

  // Observe n cycles with the inputs the caller has set; pops are scored against exp_q.
  task automatic mon_cycles(input int n);
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      if (w_cv) begin
        m_pulses++;
        m_sum += int'(w_cc);
        if (m_first_pulse < 0) m_first_pulse = cyc;
        m_last_pulse = cyc;
        if (int'(w_cc) > m_cmax) m_cmax = int'(w_cc);
        if (int'(w_cc) < m_cmin) m_cmin = int'(w_cc);
      end else if (w_cc != 5'd0) begin
        m_czerr++;
      end
      if (w_ov && out_ready) begin
        m_pops++;
        if (m_first_pop < 0) m_first_pop = cyc;
        m_last_pop = cyc;
        if (exp_q.size() == 0) begin
          m_derr++;
        end else begin
          e = exp_q.pop_front();
          if (w_od !== e) m_derr++;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", ov0); end
    tests++; if (cv0 !== 1'b0) begin fails++; $display("FAIL reset_credit_valid: got %b, expected 0", cv0); end
    tests++; if (cc0 !== 5'd0) begin fails++; $display("FAIL reset_credit_count: got %0d, expected 0", cc0); end
    tests++; if (of0 !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, expected 0", of0); end
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hA5;
    #1;
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL no_fallthrough: got %b, expected 0", ov0); end
    tick();
    in_valid = 1'b0;
    tests++; if (ov0 !== 1'b1) begin fails++; $display("FAIL first_push_valid: got %b, expected 1", ov0); end
    tests++; if (od0 !== 64'hA5) begin fails++; $display("FAIL first_push_data: got %h, expected a5", od0); end
  endtask

  task automatic test_coalesce();
    sel = 1'b0;
    do_reset();
    push_words(4, 64'h1000);
    mon_clear();
    out_ready = 1'b1;
    mon_cycles(20);
    out_ready = 1'b0;
    tests++; if (m_pops !== 4) begin fails++; $display("FAIL coal_pops: got %0d, expected 4", m_pops); end
    tests++; if (m_derr !== 0) begin fails++; $display("FAIL coal_data: got %0d errors, expected 0", m_derr); end
    tests++; if (m_pulses !== 1) begin fails++; $display("FAIL coal_pulses: got %0d, expected 1", m_pulses); end
    tests++; if (m_sum !== 4) begin fails++; $display("FAIL coal_count: got %0d, expected 4", m_sum); end
    tests++; if (m_last_pulse - m_last_pop !== 2) begin fails++; $display("FAIL coal_latency: got %0d, expected 2", m_last_pulse - m_last_pop); end
    tests++; if (m_czerr !== 0) begin fails++; $display("FAIL coal_count_idle: got %0d nonzero, expected 0", m_czerr); end
  endtask

  task automatic test_timeout();
    sel = 1'b0;
    do_reset();
    push_words(1, 64'h2000);
    mon_clear();
    out_ready = 1'b1;
    mon_cycles(1);
    out_ready = 1'b0;
    mon_cycles(25);
    tests++; if (m_pops !== 1) begin fails++; $display("FAIL tmo_pops: got %0d, expected 1", m_pops); end
    tests++; if (m_pulses !== 1) begin fails++; $display("FAIL tmo_pulses: got %0d, expected 1", m_pulses); end
    tests++; if (m_sum !== 1) begin fails++; $display("FAIL tmo_count: got %0d, expected 1", m_sum); end
    tests++; if (m_last_pulse - m_last_pop !== 10) begin fails++; $display("FAIL tmo_latency: got %0d, expected 10", m_last_pulse - m_last_pop); end
  endtask

  task automatic test_overflow();
    sel = 1'b0;
    do_reset();
    push_words(16, 64'h3000);
    tests++; if (of0 !== 1'b0) begin fails++; $display("FAIL ovf_full_no_flag: got %b, expected 0", of0); end
    in_valid = 1'b1;
    in_data = 64'hDEAD;
    tick();
    in_valid = 1'b0;
    tests++; if (of0 !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b, expected 1", of0); end
    mon_clear();
    out_ready = 1'b1;
    mon_cycles(25);
    out_ready = 1'b0;
    tests++; if (m_pops !== 16) begin fails++; $display("FAIL ovf_drain_pops: got %0d, expected 16", m_pops); end
    tests++; if (m_derr !== 0) begin fails++; $display("FAIL ovf_drain_data: got %0d errors, expected 0", m_derr); end
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b, expected 0", ov0); end
    tests++; if (of0 !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b, expected 1", of0); end
    tests++; if (m_sum !== 16) begin fails++; $display("FAIL ovf_credits: got %0d, expected 16", m_sum); end
    do_reset();
    tests++; if (of0 !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %b, expected 0", of0); end
  endtask

  task automatic test_full_pushpop();
    sel = 1'b0;
    do_reset();
    push_words(16, 64'h4000);
    mon_clear();
    in_valid = 1'b1;
    in_data = 64'h4444;
    exp_q.push_back(in_data);
    out_ready = 1'b1;
    mon_cycles(1);
    in_valid = 1'b0;
    tests++; if (of0 !== 1'b0) begin fails++; $display("FAIL full_pp_overflow: got %b, expected 0", of0); end
    mon_cycles(40);
    out_ready = 1'b0;
    tests++; if (m_pops !== 17) begin fails++; $display("FAIL full_pp_pops: got %0d, expected 17", m_pops); end
    tests++; if (m_derr !== 0) begin fails++; $display("FAIL full_pp_data: got %0d errors, expected 0", m_derr); end
    tests++; if (m_sum !== 17) begin fails++; $display("FAIL full_pp_credits: got %0d, expected 17", m_sum); end
  endtask

  task automatic test_coalesce1();
    sel = 1'b1;
    do_reset();
    push_words(6, 64'h5000);
    mon_clear();
    out_ready = 1'b1;
    mon_cycles(20);
    out_ready = 1'b0;
    tests++; if (m_pops !== 6) begin fails++; $display("FAIL c1_pops: got %0d, expected 6", m_pops); end
    tests++; if (m_pulses !== 6) begin fails++; $display("FAIL c1_pulses: got %0d, expected 6", m_pulses); end
    tests++; if (m_cmax !== 1) begin fails++; $display("FAIL c1_count_max: got %0d, expected 1", m_cmax); end
    tests++; if (m_sum !== 6) begin fails++; $display("FAIL c1_sum: got %0d, expected 6", m_sum); end
    tests++; if (m_derr !== 0) begin fails++; $display("FAIL c1_data: got %0d errors, expected 0", m_derr); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    do_reset();
    push_words(12, 64'h6000);
    mon_clear();
    out_ready = 1'b1;
    mon_cycles(20);
    out_ready = 1'b0;
    tests++; if (m_pops !== 12) begin fails++; $display("FAIL b2b_pops: got %0d, expected 12", m_pops); end
    tests++; if (m_pulses !== 3) begin fails++; $display("FAIL b2b_pulses: got %0d, expected 3", m_pulses); end
    tests++; if (m_cmin !== 4 || m_cmax !== 4) begin fails++; $display("FAIL b2b_counts: got min %0d max %0d, expected 4", m_cmin, m_cmax); end
    tests++; if (m_first_pulse - m_first_pop !== 5) begin fails++; $display("FAIL b2b_first: got %0d, expected 5", m_first_pulse - m_first_pop); end
    tests++; if (m_last_pulse - m_first_pulse !== 8) begin fails++; $display("FAIL b2b_spacing: got %0d, expected 8", m_last_pulse - m_first_pulse); end
  endtask

  task automatic test_random();
    int sender_cnt;
    logic [63:0] e;
    sel = 1'b0;
    do_reset();
    mon_clear();
    sender_cnt = 16;
    for (int i = 0; i < 10000; i++) begin
      if (w_cv) begin
        sender_cnt += int'(w_cc);
        m_sum += int'(w_cc);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (sender_cnt > 0 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data = {$urandom, $urandom};
        exp_q.push_back(in_data);
        sender_cnt--;
      end else begin
        in_valid = 1'b0;
      end
      if (w_ov && out_ready) begin
        m_pops++;
        if (exp_q.size() == 0) m_derr++;
        else begin
          e = exp_q.pop_front();
          if (w_od !== e) m_derr++;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (w_cv) begin
        sender_cnt += int'(w_cc);
        m_sum += int'(w_cc);
      end
      if (w_ov && out_ready) begin
        m_pops++;
        if (exp_q.size() == 0) m_derr++;
        else begin
          e = exp_q.pop_front();
          if (w_od !== e) m_derr++;
        end
      end
      tick();
    end
    tests++; if (of0 !== 1'b0) begin fails++; $display("FAIL rand_overflow: got %b, expected 0", of0); end
    tests++; if (m_derr !== 0) begin fails++; $display("FAIL rand_data: got %0d errors, expected 0", m_derr); end
    tests++; if (m_sum !== m_pops) begin fails++; $display("FAIL rand_conservation: got %0d credits, expected %0d", m_sum, m_pops); end
    tests++; if (sender_cnt !== 16) begin fails++; $display("FAIL rand_sender_cnt: got %0d, expected 16", sender_cnt); end
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL rand_drained: got %0d left, expected 0", exp_q.size()); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    sel = 1'b0;
    test_reset();
    test_coalesce();
    test_timeout();
    test_overflow();
    test_full_pushpop();
    test_coalesce1();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
